// File: rtl/bus_arbiter2.sv
// Two-master / one-slave bus arbiter.
// Master 0 is the instruction fetch port, master 1 the load/store port. Their
// transactions are serialised onto one slave port. Under contention the master
// not served last wins. A slave that stalls for TIMEOUT busy cycles is
// abandoned and the granted master gets an ack with err set.
//
// Handshake: a master raises mX_req with its command fields and holds them
// stable until it sees a one-cycle mX_ack; the arbiter raises s_req (registered)
// and holds it until the slave answers with a one-cycle s_ack, whose s_rdata is
// passed straight through to the granted master in that same cycle.
module bus_arbiter2 #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    // master 0 (instruction fetch)
    input  logic                m0_req,
    input  logic                m0_we,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_be,
    output logic                m0_ack,
    output logic                m0_err,
    output logic [DATA_W-1:0]   m0_rdata,
    // master 1 (load/store)
    input  logic                m1_req,
    input  logic                m1_we,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_be,
    output logic                m1_ack,
    output logic                m1_err,
    output logic [DATA_W-1:0]   m1_rdata,
    // slave port
    output logic                s_req,
    output logic                s_we,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_be,
    input  logic                s_ack,
    input  logic [DATA_W-1:0]   s_rdata,
    // debug: 1 while a transaction is outstanding (BUSY)
    output logic                dbg_state
);

    localparam int TCNT_W = $clog2(TIMEOUT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e              state_q;
    logic                grant_q;
    logic                last_q;
    logic                s_req_q;
    logic [TCNT_W-1:0]   tcnt_q;

    logic                grant_d;
    logic                busy;
    logic                done_ok;
    logic                done_to;
    logic                done;
    logic                sel_m1;

    assign busy    = (state_q == BUSY);
    // A real s_ack always beats the timeout in the same cycle.
    assign done_ok = busy & s_ack;
    assign done_to = busy & ~s_ack & (tcnt_q == TCNT_LAST);
    assign done    = done_ok | done_to;

    // Pick the next master: lone requester wins, otherwise the one not served last.
    always_comb begin
        grant_d = 1'b0;
        if (m0_req && m1_req) begin
            grant_d = ~last_q;
        end else begin
            grant_d = m1_req;
        end
    end

    // Arbiter FSM: accept a request in IDLE, wait for s_ack or timeout in BUSY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b0;
            s_req_q <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req || m1_req) begin
                        state_q <= BUSY;
                        grant_q <= grant_d;
                        s_req_q <= 1'b1;
                        tcnt_q  <= '0;
                    end else begin
                        s_req_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        state_q <= IDLE;
                        s_req_q <= 1'b0;
                        last_q  <= grant_q;
                        tcnt_q  <= '0;
                    end else begin
                        tcnt_q  <= tcnt_q + TCNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    s_req_q <= 1'b0;
                    tcnt_q  <= '0;
                end
            endcase
        end
    end

    assign s_req     = s_req_q;
    assign dbg_state = busy;

    // Slave command mux: granted master while BUSY, master 0 otherwise (ignored by slave).
    assign sel_m1 = busy & grant_q;

    always_comb begin
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_be    = m0_be;
        if (sel_m1) begin
            s_we    = m1_we;
            s_addr  = m1_addr;
            s_wdata = m1_wdata;
            s_be    = m1_be;
        end
    end

    // Completion routing: only the granted master sees ack/err/rdata; the other reads zero.
    always_comb begin
        m0_ack   = done & ~grant_q;
        m1_ack   = done &  grant_q;
        m0_err   = done_to & ~grant_q;
        m1_err   = done_to &  grant_q;
        m0_rdata = '0;
        m1_rdata = '0;
        if (done_ok && !grant_q) begin
            m0_rdata = s_rdata;
        end
        if (done_ok && grant_q) begin
            m1_rdata = s_rdata;
        end
    end

endmodule

// File: tb/tb_bus_arbiter2.sv
// Self-checking bench for bus_arbiter2 (TIMEOUT = 4).
// Each row of a vector table raises master requests and plays the slave for
// one transaction; the expected completion is queued on the scoreboard when
// the request is driven and compared by a monitor when an ack appears.
module tb_bus_arbiter2;

    localparam int TMO  = 4;
    localparam int SB_W = 34;    // {master, err, rdata}
    localparam int NEVER = 99;   // slave delay that never acks

    logic        clk;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_be, m1_be;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we, s_ack;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [3:0]  s_be;
    logic        dbg_state;

    bus_arbiter2 #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_ack(s_ack), .s_rdata(s_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [SB_W-1:0] exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: late in each cycle, any ack pops one expected completion.
    always @(negedge clk) begin
        logic [SB_W-1:0] act;
        logic [SB_W-1:0] exp;
        #3;
        if (rst_n && (m0_ack || m1_ack)) begin
            chk("single_ack", {m0_ack, m1_ack} == 2'b11, 0);
            chk("other_rdata_zero", m1_ack ? m0_rdata : m1_rdata, 0);
            chk("other_err_zero", m1_ack ? m0_err : m1_err, 0);
            act = {m1_ack, m1_ack ? m1_err : m0_err, m1_ack ? m1_rdata : m0_rdata};
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_ack", act, 0);
            end else begin
                exp = exp_q.pop_front();
                chk("sb_completion", act, exp);
            end
        end
    end

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0]  mask;    // masters raised by this row (if not already pending)
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          delay;   // slave ack in this BUSY cycle (0 = first)
        logic [31:0] rdata;
        logic        grant;   // master expected to be served
        logic        err;     // timeout expected
    } row_t;

    function automatic row_t mk(logic [1:0] mask, logic we, logic [31:0] addr, logic [31:0] wdata,
                                logic [3:0] be, int delay, logic [31:0] rdata, logic grant, logic err);
        row_t r;
        r.mask = mask; r.we = we; r.addr = addr; r.wdata = wdata; r.be = be;
        r.delay = delay; r.rdata = rdata; r.grant = grant; r.err = err;
        return r;
    endfunction

    logic pend[2];
    logic last_m;

    // Reference arbitration: lone requester wins, both -> not the one served last.
    function automatic logic model_grant(logic [1:0] mask);
        logic r0, r1;
        r0 = pend[0] | mask[0];
        r1 = pend[1] | mask[1];
        if (r0 && r1) return ~last_m;
        return r1;
    endfunction

    // ---------------- driver tasks ----------------
    // When both masters are raised together, master 1 gets derived fields so the
    // slave-side mux check can tell them apart.
    task automatic raise(input int x, input row_t r);
        logic alt;
        alt = (r.mask == 2'b11) && (x == 1);
        if (x == 0) begin
            m0_we = r.we; m0_addr = r.addr; m0_wdata = r.wdata; m0_be = r.be; m0_req = 1'b1;
        end else begin
            m1_we = r.we ^ alt; m1_addr = r.addr + (alt ? 32'h40 : 32'h0);
            m1_wdata = alt ? ~r.wdata : r.wdata; m1_be = r.be; m1_req = 1'b1;
        end
        pend[x] = 1'b1;
    endtask

    task automatic run_row(input row_t r);
        bit   seen;
        bit   got;
        int   cyc;
        logic g_act;
        int   exp_cyc;
        if (r.mask[0] && !pend[0]) raise(0, r);
        if (r.mask[1] && !pend[1]) raise(1, r);
        exp_q.push_back({r.grant, r.err, r.err ? 32'h0 : r.rdata});
        exp_cyc = r.err ? TMO - 1 : r.delay;
        // s_req must rise on the first edge after the request
        seen = 0;
        for (int w = 0; w < 8; w++) begin
            @(negedge clk); #1;
            if (s_req) begin
                seen = 1;
                chk("req_latency", w, 0);
                break;
            end
        end
        if (!seen) begin
            chk("s_req_timeout", 0, 1);
            void'(exp_q.pop_back());
            return;
        end
        chk("busy_state", dbg_state, 1);
        chk("s_we",    s_we,    r.grant ? m1_we    : m0_we);
        chk("s_addr",  s_addr,  r.grant ? m1_addr  : m0_addr);
        chk("s_wdata", s_wdata, r.grant ? m1_wdata : m0_wdata);
        chk("s_be",    s_be,    r.grant ? m1_be    : m0_be);
        // play the slave
        got = 0; cyc = 0; g_act = r.grant;
        for (int c = 0; c < 12; c++) begin
            if (c != 0) begin @(negedge clk); #1; end
            if (c == r.delay) begin s_ack = 1'b1; s_rdata = r.rdata; end
            #1;
            if (m0_ack || m1_ack) begin
                got = 1; cyc = c; g_act = m1_ack;
                break;
            end
        end
        if (!got) begin
            chk("ack_timeout", 0, 1);
            void'(exp_q.pop_back());
        end else begin
            chk("ack_cycle", cyc, exp_cyc);
        end
        @(negedge clk);
        s_ack = 1'b0; s_rdata = 32'h0;
        if (g_act) m1_req = 1'b0; else m0_req = 1'b0;
        pend[g_act] = 1'b0;
        last_m = g_act;
        #1;
        chk("idle_gap_s_req", s_req, 0);
        chk("idle_gap_acks", {m0_ack, m1_ack}, 0);
    endtask

    row_t vec[13];

    initial begin
        row_t r;
        logic [1:0] mk_mask;
        int d;

        vec[0]  = mk(2'b11, 1'b0, 32'h300, 32'h0000_0000, 4'hF, 1, 32'h1111_0000, 1'b1, 1'b0);
        vec[1]  = mk(2'b00, 1'b0, 32'h0,   32'h0,         4'h0, 0, 32'h2222_0000, 1'b0, 1'b0);
        vec[2]  = mk(2'b11, 1'b0, 32'h310, 32'hA5A5_0000, 4'h3, 2, 32'h3333_0000, 1'b1, 1'b0);
        vec[3]  = mk(2'b11, 1'b1, 32'h320, 32'h5A5A_1111, 4'hC, 0, 32'h4444_0000, 1'b0, 1'b0);
        vec[4]  = mk(2'b00, 1'b0, 32'h0,   32'h0,         4'h0, 1, 32'h5555_0000, 1'b1, 1'b0);
        vec[5]  = mk(2'b10, 1'b0, 32'h100, 32'h0,         4'hF, 2, 32'hCAFE_0001, 1'b1, 1'b0);
        vec[6]  = mk(2'b01, 1'b1, 32'h200, 32'h1234_5678, 4'hF, 0, 32'h0,         1'b0, 1'b0);
        vec[7]  = mk(2'b10, 1'b0, 32'h500, 32'h0,         4'hF, NEVER, 32'h0BAD_0BAD, 1'b1, 1'b1);
        vec[8]  = mk(2'b01, 1'b0, 32'h600, 32'h0,         4'hF, 1, 32'h0060_0600, 1'b0, 1'b0);
        vec[9]  = mk(2'b01, 1'b0, 32'h700, 32'h0,         4'hF, 3, 32'hDEAD_BEEF, 1'b0, 1'b0);
        vec[10] = mk(2'b01, 1'b1, 32'h800, 32'h8888_8888, 4'h3, NEVER, 32'h0,     1'b0, 1'b1);
        vec[11] = mk(2'b11, 1'b0, 32'h900, 32'h9999_0000, 4'hF, 0, 32'h9090_9090, 1'b1, 1'b0);
        vec[12] = mk(2'b00, 1'b0, 32'h0,   32'h0,         4'h0, 2, 32'hABCD_0012, 1'b0, 1'b0);

        rst_n = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_be = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_be = 0;
        s_ack = 0; s_rdata = 0;
        pend[0] = 0; pend[1] = 0; last_m = 0;

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_req", s_req, 0);
        chk("rst_acks", {m0_ack, m1_ack}, 0);
        chk("rst_errs", {m0_err, m1_err}, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // s_ack while IDLE must not produce any master ack
        @(negedge clk);
        s_ack = 1'b1; s_rdata = 32'h5555_AAAA;
        #1;
        chk("idle_sack_acks", {m0_ack, m1_ack}, 0);
        chk("idle_sack_rdata", {m0_rdata, m1_rdata}, 0);
        @(negedge clk);
        s_ack = 1'b0; s_rdata = 32'h0;
        #1;
        chk("idle_sack_s_req", s_req, 0);

        // table-driven vectors
        for (int i = 0; i < 13; i++) begin
            run_row(vec[i]);
        end

        // randomised rows, expected grant from the reference arbitration
        for (int i = 0; i < 10; i++) begin
            mk_mask = 2'($urandom_range(0, 3));
            if (mk_mask == 2'b00 && !pend[0] && !pend[1]) mk_mask = 2'b01;
            d = $urandom_range(0, 5);
            r = mk(mk_mask, 1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, $urandom(),
                   4'($urandom_range(0, 15)), d, $urandom(), model_grant(mk_mask), d >= TMO);
            run_row(r);
        end
        while (pend[0] || pend[1]) begin
            run_row(mk(2'b00, 1'b0, 32'h0, 32'h0, 4'h0, 0, 32'h7777_0000 + 32'(checks),
                       model_grant(2'b00), 1'b0));
        end

        // reset pulsed in the middle of a transaction
        @(negedge clk);
        m0_we = 1'b0; m0_addr = 32'hA00; m0_be = 4'hF; m0_req = 1'b1;
        @(negedge clk); #1;
        chk("rstmid_s_req_up", s_req, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_s_req", s_req, 0);
        chk("rstmid_acks", {m0_ack, m1_ack}, 0);
        chk("rstmid_state", dbg_state, 0);
        @(negedge clk);
        m0_req = 1'b0; pend[0] = 0; pend[1] = 0; last_m = 0;
        rst_n = 1'b1;
        run_row(mk(2'b11, 1'b0, 32'hB00, 32'h0, 4'hF, 1, 32'h0B0B_0B0B, 1'b1, 1'b0));
        run_row(mk(2'b00, 1'b0, 32'h0,   32'h0, 4'h0, 0, 32'h0C0C_0C0C, 1'b0, 1'b0));

        repeat (2) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
